pit_ctrl_word_unit: RTL
=======================

Name: pit_ctrl_word_unit

Overview:
- Synchronous, parametrised control-word decoder and register file for the programmable interval timer.
- Accepts bus writes aimed at the control address and keeps one 6-bit control word (RW, M, BCD) per counter channel.
- Decodes counter-latch and read-back commands into one-cycle pulses, and tracks a per-channel null-count flag.
- Sits between the bus interface (read/write strobe generation, address decode) and the counter channel instances.

Parameters:
- NUM_CH, 3, number of counter channels; legal range 1..3, limited by the 2-bit SC field.
- FOLD_MODES, 1, when 1 the mode fields 110/111 are stored as 010/011 (modes 6/7 alias to 2/3); when 0 they are stored verbatim.
- RST_CW, 6'b11_000_0, control word loaded into every channel on reset (RW=LSB-then-MSB, mode 0, binary).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- wr_en  in  1  one-cycle write strobe, already address-qualified for the control register.
- wr_data  in  8  control byte: [7:6]=SC, [5:4]=RW, [3:1]=M, [0]=BCD.
- rd_en  in  1  one-cycle read strobe for the control address.
- rd_data  out  8  last accepted control byte, registered.
- count_loaded_i  in  NUM_CH  per-channel pulse from a counter when a new initial count has been transferred to its CE.
- cw_o  out  6*NUM_CH  stored control word per channel; channel i occupies bits [6i+5:6i].
- cw_load_o  out  NUM_CH  one-cycle pulse: channel i was reprogrammed this cycle.
- cnt_latch_o  out  NUM_CH  one-cycle pulse: latch count for channel i.
- sts_latch_o  out  NUM_CH  one-cycle pulse: latch status for channel i.
- null_cnt_o  out  NUM_CH  per-channel null-count flag.

Behaviour:
- Reset (asynchronous): every cw_o slice = RST_CW (with FOLD_MODES applied); rd_data=0; all pulse outputs=0; null_cnt_o all 1.
- All pulse outputs are registered and appear in the cycle after wr_en, high for exactly one cycle.
- wr_en with SC<NUM_CH and RW!=00 (programming command):
  - channel SC cw <= {RW, M', BCD}, where M' is M after folding.
  - cw_load_o[SC]=1 for one cycle.
  - null_cnt_o[SC]<=1.
- wr_en with SC<NUM_CH and RW=00 (counter-latch command):
  - cw unchanged.
  - cnt_latch_o[SC]=1 for one cycle.
- wr_en with SC=11 (read-back command):
  - For each i<NUM_CH with wr_data[1+i]=1: cnt_latch_o[i]=~wr_data[5] and sts_latch_o[i]=~wr_data[4].
  - Several channels may fire in the same cycle.
  - wr_data[5:4]=11 gives no pulses.
  - cw unchanged.
- wr_en with NUM_CH<=SC<3 (unimplemented channel): ignored entirely; rd_data is still updated.
- rd_data is updated with wr_data on every wr_en. rd_en has no side effects; rd_data is always valid.
- null_cnt_o[i] is cleared on count_loaded_i[i]. If a programming write to channel i and count_loaded_i[i] occur in the same cycle, the set wins (flag=1).
- wr_en arriving during a pulse cycle is accepted normally, so back-to-back writes produce back-to-back pulses.
- Reset asserted mid-pulse: pulses drop immediately (asynchronous).

Decomposition:
- Shared package pit_pkg:
  - SC/RW/M field positions.
  - RW encodings: RW_LATCH=00, RW_LSB=01, RW_MSB=10, RW_LSB_MSB=11.
  - SC_READBACK=2'b11.
  - Mode constants M0..M5.
  - Function fold_mode(m, en).
- One natural sub-module: pit_cw_channel, instantiated NUM_CH times. Each instance holds one cw register plus its null-count flag; the top level decodes commands and generates the pulses.

Test Plan:
- Reset, no writes -> each cw_o slice=6'b110000, null_cnt_o=3'b111, no pulses, rd_data=0.
- Write 8'h74 (ch1, RW=11, mode 2, binary) -> cw_o[11:6]=6'b110100, cw_load_o=3'b010 for one cycle, null_cnt_o[1]=1; later count_loaded_i[1] -> null_cnt_o[1]=0.
- Write 8'h8E (ch2, RW=00) -> cnt_latch_o=3'b100 for one cycle, cw_o[17:12] unchanged; then write 8'hBC (ch2, mode 6) with FOLD_MODES=1 -> stored M=3'b010.
- Read-back 8'hCE (latch count and status, ch0/1/2) -> cnt_latch_o=3'b111 and sts_latch_o=3'b111 in the same cycle; 8'hE2 -> sts_latch_o=3'b001 only; 8'hF2 -> no pulses.
- Same-cycle write 8'h30 (ch0 program) and count_loaded_i[0]=1 -> null_cnt_o[0]=1; NUM_CH=2 with write 8'h94 (SC=10) -> all cw unchanged, no pulses, rd_data=8'h94.
- Assert rst asynchronously during a cw_load_o pulse -> pulse drops before the next clk edge, all registers return to reset values.

Source files
------------

// File: rtl/pit_pkg.sv
// pit_pkg: shared control-word field positions, encodings and mode folding.
package pit_pkg;
  localparam int SC_HI = 7;
  localparam int SC_LO = 6;
  localparam int RW_HI = 5;
  localparam int RW_LO = 4;
  localparam int M_HI = 3;
  localparam int M_LO = 1;
  localparam int BCD_BIT = 0;
  typedef enum logic [1:0] {
    RW_LATCH   = 2'b00,
    RW_LSB     = 2'b01,
    RW_MSB     = 2'b10,
    RW_LSB_MSB = 2'b11
  } rw_e;
  localparam logic [1:0] SC_READBACK = 2'b11;
  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;
  // Modes 6/7 are don't-care aliases of 2/3 on the 8254.
  function automatic logic [2:0] fold_mode(input logic [2:0] m, input logic en);
    return (en && m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
  endfunction
  function automatic logic [5:0] fold_cw(input logic [5:0] cw, input logic en);
    return {cw[5:4], fold_mode(cw[3:1], en), cw[0]};
  endfunction
endpackage

// File: rtl/pit_ctrl_word_unit_if.sv
// pit_ctrl_word_unit_if: control-address bus between the bus interface and the control-word unit.
interface pit_ctrl_word_unit_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  modport master (output wr_en, output wr_data, output rd_en, input rd_data);
  modport slave (input wr_en, input wr_data, input rd_en, output rd_data);
endinterface

// File: rtl/pit_cw_channel.sv
// pit_cw_channel: one channel's stored control word and null-count flag.
module pit_cw_channel
  import pit_pkg::*;
#(
  parameter bit FOLD_MODES = 1'b1,
  parameter logic [5:0] RST_CW = 6'b11_000_0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] cwIn,
  input  logic       countLoaded,
  output logic [5:0] cw,
  output logic       nullCnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw      <= fold_cw(RST_CW, FOLD_MODES);
      nullCnt <= 1'b1;
    end else begin
      if (load) cw <= fold_cw(cwIn, FOLD_MODES);
      nullCnt <= load | (nullCnt & ~countLoaded);
    end
  end
endmodule

// File: rtl/pit_ctrl_word_unit.sv
// pit_ctrl_word_unit: control-word decoder, per-channel register file and command pulse generator.
module pit_ctrl_word_unit
  import pit_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter bit FOLD_MODES = 1'b1,
  parameter logic [5:0] RST_CW = 6'b11_000_0
) (
  input  logic                  clk,
  input  logic                  rst,
  pit_ctrl_word_unit_if.slave   bus,
  input  logic [NUM_CH-1:0]     count_loaded_i,
  output logic [6*NUM_CH-1:0]   cw_o,
  output logic [NUM_CH-1:0]     cw_load_o,
  output logic [NUM_CH-1:0]     cnt_latch_o,
  output logic [NUM_CH-1:0]     sts_latch_o,
  output logic [NUM_CH-1:0]     null_cnt_o
);
  logic [1:0] sc;
  rw_e rw;
  logic isChan, isRb;
  logic [NUM_CH-1:0] loadNext, cntNext, stsNext;
  assign sc = bus.wr_data[SC_HI:SC_LO];
  assign rw = rw_e'(bus.wr_data[RW_HI:RW_LO]);
  assign isChan = bus.wr_en && int'(sc) < NUM_CH;
  assign isRb = bus.wr_en && sc == SC_READBACK;
  // Read-back bits are active-low requests: bit 5 = count, bit 4 = status.
  always_comb begin
    loadNext = '0;
    cntNext = '0;
    stsNext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      loadNext[i] = isChan && int'(sc) == i && rw != RW_LATCH;
      cntNext[i] = (isChan && int'(sc) == i && rw == RW_LATCH) ||
                   (isRb && bus.wr_data[M_LO+i] && !bus.wr_data[RW_HI]);
      stsNext[i] = isRb && bus.wr_data[M_LO+i] && !bus.wr_data[RW_LO];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_load_o   <= '0;
      cnt_latch_o <= '0;
      sts_latch_o <= '0;
      bus.rd_data <= '0;
    end else begin
      cw_load_o   <= loadNext;
      cnt_latch_o <= cntNext;
      sts_latch_o <= stsNext;
      if (bus.wr_en) bus.rd_data <= bus.wr_data;
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    pit_cw_channel #(
      .FOLD_MODES(FOLD_MODES),
      .RST_CW    (RST_CW)
    ) uCh (
      .clk        (clk),
      .rst        (rst),
      .load       (loadNext[g]),
      .cwIn       (bus.wr_data[5:0]),
      .countLoaded(count_loaded_i[g]),
      .cw         (cw_o[6*g+:6]),
      .nullCnt    (null_cnt_o[g])
    );
  end
endmodule
